// File: rtl/text_lcd_pkg.sv
// text_lcd_pkg: shared types and constants for the text LCD reader and write sequencer.
package text_lcd_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_E_HIGH, ST_HOLD, ST_GAP} lcd_state_e;
  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA = 1'b1;
  localparam int BF_BIT = 7;
  localparam int T_AS_DEF = 2;
  localparam int T_PW_DEF = 8;
  localparam int T_H_DEF = 2;
  localparam int T_GAP_DEF = 4;
  localparam int POLL_MAX_DEF = 1000;
endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter whose expire pulse marks the last cycle of a phase.
module lcd_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/text_lcd_reader.sv
// text_lcd_reader: HD44780 read cycles (BF/AC or data) with optional busy-flag polling.
module text_lcd_reader
  import text_lcd_pkg::*;
#(
  parameter int T_AS     = T_AS_DEF,
  parameter int T_PW     = T_PW_DEF,
  parameter int T_H      = T_H_DEF,
  parameter int T_GAP    = T_GAP_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_bf,
  output logic [6:0] rsp_ac,
  output logic       rsp_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RD_EN
);
  localparam int TW = 8;
  lcd_state_e state_q, state_d;
  logic rs_q, rs_d, poll_q, poll_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0] cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
  logic ld, tmr_exp;
  logic [TW-1:0] ld_val;
  lcd_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ld),
    .val_i    (ld_val),
    .expire_o (tmr_exp)
  );
  always_comb begin
    state_d = state_q;
    rs_d = rs_q;
    poll_d = poll_q;
    pcnt_d = pcnt_q;
    cap_d = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_to_d = rsp_to_q;
    ld = 1'b0;
    ld_val = '0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_SETUP;
        rs_d = req_rs;
        poll_d = req_poll & ~req_rs;
        pcnt_d = '0;
        ld = 1'b1;
        ld_val = TW'(T_AS);
      end
      ST_SETUP: if (tmr_exp) begin
        state_d = ST_E_HIGH;
        ld = 1'b1;
        ld_val = TW'(T_PW);
      end
      ST_E_HIGH: if (tmr_exp) begin
        state_d = ST_HOLD;
        cap_d = LCD_DATA_IN;
        ld = 1'b1;
        ld_val = TW'(T_H);
      end
      ST_HOLD: if (tmr_exp) begin
        state_d = ST_GAP;
        ld = 1'b1;
        ld_val = TW'(T_GAP);
      end
      ST_GAP: if (tmr_exp) begin
        // Re-poll only while busy and the read budget is not yet spent
        if (poll_q && cap_q[BF_BIT] && (pcnt_q + 16'd1 < 16'(POLL_MAX))) begin
          state_d = ST_SETUP;
          pcnt_d = pcnt_q + 16'd1;
          ld = 1'b1;
          ld_val = TW'(T_AS);
        end else begin
          state_d = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d = cap_q;
          rsp_to_d = poll_q & cap_q[BF_BIT];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rs_q <= 1'b0;
      poll_q <= 1'b0;
      pcnt_q <= '0;
      cap_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q <= rs_d;
      poll_q <= poll_d;
      pcnt_q <= pcnt_d;
      cap_q <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q <= rsp_to_d;
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign LCD_E = state_q == ST_E_HIGH;
  assign LCD_RD_EN = state_q inside {ST_SETUP, ST_E_HIGH, ST_HOLD};
  assign LCD_RW = LCD_RD_EN;
  assign LCD_RS = LCD_RD_EN & rs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_bf = rsp_data_q[BF_BIT];
  assign rsp_ac = rsp_data_q[BF_BIT-1:0];
  assign rsp_timeout = rsp_to_q;
endmodule
